// File: rtl/obi_host_port.sv
`default_nettype none
// ============================================================================
// Module      : obi_host_port
// Description : OBI manager-side port. Takes read/write commands from an
//               internal client, drives the OBI A channel (req/gnt), collects
//               R-channel responses into an in-order FIFO and returns them to
//               the client over a valid/ready interface. Tracks in-flight
//               transactions and flags protocol violations and timeouts.
// Ports       : clk, rst_n                         clock, async active-low reset
//               cmd_valid/ready/we/addr/be/wdata    client command channel
//               obi_req/gnt/addr/we/be/wdata        OBI A channel
//               obi_rvalid/rready/rdata/err         OBI R channel
//               rsp_valid/ready/rdata/err/we        client response channel
//               outstanding                         granted, unanswered count
//               proto_err, timeout_err              sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module obi_host_port #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_we,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr,
    input  logic [DATA_WIDTH/8-1:0]            cmd_be,
    input  logic [DATA_WIDTH-1:0]              cmd_wdata,
    output logic                               obi_req,
    input  logic                               obi_gnt,
    output logic [ADDR_WIDTH-1:0]              obi_addr,
    output logic                               obi_we,
    output logic [DATA_WIDTH/8-1:0]            obi_be,
    output logic [DATA_WIDTH-1:0]              obi_wdata,
    input  logic                               obi_rvalid,
    output logic                               obi_rready,
    input  logic [DATA_WIDTH-1:0]              obi_rdata,
    input  logic                               obi_err,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic                               rsp_we,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               proto_err,
    output logic                               timeout_err
);

    localparam int C_PW = $clog2(MAX_OUTSTANDING);
    localparam int C_CW = C_PW + 1;
    localparam int C_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int C_BW = DATA_WIDTH / 8;
    localparam logic [C_CW:0]   C_MAX_OCC = (C_CW + 1)'(MAX_OUTSTANDING);
    localparam logic [C_TW-1:0] C_TIMEOUT = C_TW'(TIMEOUT_CYCLES);

    // Control state
    logic                   r_active;
    logic                   r_a_pending;
    logic [ADDR_WIDTH-1:0]  r_a_addr;
    logic                   r_a_we;
    logic [C_BW-1:0]        r_a_be;
    logic [DATA_WIDTH-1:0]  r_a_wdata;
    logic [C_CW-1:0]        r_outstanding;
    logic [C_PW-1:0]        r_tag_wptr;
    logic [C_PW-1:0]        r_tag_rptr;
    logic [C_PW-1:0]        r_fifo_wptr;
    logic [C_PW-1:0]        r_fifo_rptr;
    logic [C_CW-1:0]        r_fifo_count;
    logic                   r_proto_err;
    logic                   r_timeout_err;
    logic [C_TW-1:0]        r_timer;

    // Storage (no reset needed: validity is tracked by pointers/counts)
    logic                   r_tag_we   [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0]  r_fifo_data[MAX_OUTSTANDING];
    logic                   r_fifo_err [MAX_OUTSTANDING];
    logic                   r_fifo_we  [MAX_OUTSTANDING];

    logic                   w_cmd_fire;
    logic                   w_gnt_fire;
    logic                   w_rsp_in;
    logic                   w_rsp_out;
    logic [C_CW:0]          w_occ;
    logic                   w_tag_head;

    // Every slot that could still produce a response is counted, so once the
    // client is admitted the FIFO is guaranteed room and rready can stay high.
    assign w_occ      = (C_CW + 1)'(r_a_pending) + (C_CW + 1)'(r_outstanding)
                      + (C_CW + 1)'(r_fifo_count);
    assign cmd_ready  = r_active && !r_a_pending && (w_occ < C_MAX_OCC);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_gnt_fire = r_a_pending && obi_gnt;
    assign w_rsp_in   = obi_rvalid && (r_outstanding != '0);
    assign w_rsp_out  = rsp_valid && rsp_ready;
    assign w_tag_head = r_tag_we[r_tag_rptr];

    assign obi_req     = r_a_pending;
    assign obi_addr    = r_a_addr;
    assign obi_we      = r_a_we;
    assign obi_be      = r_a_be;
    assign obi_wdata   = r_a_wdata;
    assign obi_rready  = r_active;
    assign outstanding = r_outstanding;
    assign proto_err   = r_proto_err;
    assign timeout_err = r_timeout_err;

    // Response outputs are forced to zero when empty so the uninitialised
    // storage never leaks onto the client bus (notably right after reset).
    assign rsp_valid = (r_fifo_count != '0);
    assign rsp_rdata = rsp_valid ? r_fifo_data[r_fifo_rptr] : '0;
    assign rsp_err   = rsp_valid && r_fifo_err[r_fifo_rptr];
    assign rsp_we    = rsp_valid && r_fifo_we[r_fifo_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_a_pending   <= 1'b0;
            r_a_addr      <= '0;
            r_a_we        <= 1'b0;
            r_a_be        <= '0;
            r_a_wdata     <= '0;
            r_outstanding <= '0;
            r_tag_wptr    <= '0;
            r_tag_rptr    <= '0;
            r_fifo_wptr   <= '0;
            r_fifo_rptr   <= '0;
            r_fifo_count  <= '0;
            r_proto_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_active <= 1'b1;

            // A channel: fields are only loaded while no request is pending,
            // so they are stable for the whole req/gnt handshake.
            if (w_cmd_fire) begin
                r_a_pending <= 1'b1;
                r_a_addr    <= cmd_addr;
                r_a_we      <= cmd_we;
                r_a_be      <= cmd_be;
                r_a_wdata   <= cmd_wdata;
            end else if (w_gnt_fire) begin
                r_a_pending <= 1'b0;
            end

            if (w_gnt_fire) begin
                r_tag_wptr <= r_tag_wptr + 1'b1;
            end
            if (w_rsp_in) begin
                r_tag_rptr <= r_tag_rptr + 1'b1;
            end

            case ({w_gnt_fire, w_rsp_in})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_rsp_in) begin
                r_fifo_wptr <= r_fifo_wptr + 1'b1;
            end
            if (w_rsp_out) begin
                r_fifo_rptr <= r_fifo_rptr + 1'b1;
            end
            case ({w_rsp_in, w_rsp_out})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase

            if (obi_rvalid && (r_outstanding == '0)) begin
                r_proto_err <= 1'b1;
            end

            // Timer measures silence on the R channel while work is in flight.
            if ((r_outstanding == '0) || obi_rvalid) begin
                r_timer <= '0;
            end else if (r_timer != C_TIMEOUT) begin
                r_timer <= r_timer + 1'b1;
                if (r_timer + 1'b1 == C_TIMEOUT) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt_fire) begin
            r_tag_we[r_tag_wptr] <= r_a_we;
        end
        if (w_rsp_in) begin
            r_fifo_data[r_fifo_wptr] <= w_tag_head ? '0 : obi_rdata;
            r_fifo_err[r_fifo_wptr]  <= obi_err;
            r_fifo_we[r_fifo_wptr]   <= w_tag_head;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_host_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_host_port
// Description : Self-checking bench for obi_host_port. A transaction-level
//               model (queues of tags and responses) predicts every output on
//               every cycle; directed scenarios add hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_host_port;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MAXO = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_be = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          obi_gnt = 1'b0, obi_rvalid = 1'b0, obi_err = 1'b0, rsp_ready = 1'b0;
    logic [DW-1:0] obi_rdata = '0;
    logic          cmd_ready, obi_req, obi_we, obi_rready, rsp_valid, rsp_err, rsp_we;
    logic          proto_err, timeout_err;
    logic [AW-1:0] obi_addr;
    logic [7:0]    obi_be;
    logic [DW-1:0] obi_wdata, rsp_rdata;
    logic [2:0]    outstanding;

    obi_host_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
                    .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
        .obi_be(obi_be), .obi_wdata(obi_wdata),
        .obi_rvalid(obi_rvalid), .obi_rready(obi_rready), .obi_rdata(obi_rdata),
        .obi_err(obi_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_we(rsp_we),
        .outstanding(outstanding), .proto_err(proto_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
        logic          w;
    } rsp_t;

    bit            m_active, m_a_pend, m_a_we, m_proto, m_tout;
    logic [AW-1:0] m_a_addr;
    logic [7:0]    m_a_be;
    logic [DW-1:0] m_a_wdata;
    bit            m_tags[$];
    rsp_t          m_rsps[$];
    int            m_timer;

    task automatic model_reset();
        m_active = 0; m_a_pend = 0; m_a_we = 0; m_proto = 0; m_tout = 0;
        m_a_addr = '0; m_a_be = '0; m_a_wdata = '0;
        m_tags.delete(); m_rsps.delete(); m_timer = 0;
    endtask

    initial model_reset();

    // Inputs change just after posedge, so at negedge they are the values
    // the next posedge will sample.
    always @(negedge clk) begin
        bit   e_rdy;
        int   n_tag;
        bit   w;
        rsp_t r;
        if (!rst_n) model_reset();
        n_tag = m_tags.size();
        e_rdy = m_active && !m_a_pend && (n_tag + m_rsps.size() < MAXO);
        chk("cmd_ready", cmd_ready, e_rdy);
        chk("obi_req", obi_req, m_a_pend);
        if (m_a_pend) begin
            chk("obi_addr", obi_addr, m_a_addr);
            chk("obi_we", obi_we, m_a_we);
            chk("obi_be", obi_be, m_a_be);
            chk("obi_wdata", obi_wdata, m_a_wdata);
        end
        chk("obi_rready", obi_rready, m_active);
        chk("rsp_valid", rsp_valid, m_rsps.size() > 0);
        if (m_rsps.size() > 0) begin
            chk("rsp_rdata", rsp_rdata, m_rsps[0].d);
            chk("rsp_err", rsp_err, m_rsps[0].e);
            chk("rsp_we", rsp_we, m_rsps[0].w);
        end
        chk("outstanding", outstanding, n_tag);
        chk("proto_err", proto_err, m_proto);
        chk("timeout_err", timeout_err, m_tout);

        if (rst_n) begin
            if (rsp_ready && m_rsps.size() > 0) void'(m_rsps.pop_front());
            if (obi_rvalid) begin
                if (n_tag > 0) begin
                    w = m_tags.pop_front();
                    r.d = w ? '0 : obi_rdata;
                    r.e = obi_err;
                    r.w = w;
                    m_rsps.push_back(r);
                end else begin
                    m_proto = 1;
                end
            end
            if (n_tag == 0 || obi_rvalid) m_timer = 0;
            else begin
                m_timer++;
                if (m_timer >= TO) m_tout = 1;
            end
            if (m_a_pend && obi_gnt) begin
                m_tags.push_back(m_a_we);
                m_a_pend = 0;
            end
            if (cmd_valid && e_rdy) begin
                m_a_pend = 1; m_a_we = cmd_we; m_a_addr = cmd_addr;
                m_a_be = cmd_be; m_a_wdata = cmd_wdata;
            end
            m_active = 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] a,
                            input logic [7:0] be, input logic [DW-1:0] wd);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_be = be; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rready", obi_rready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rready after release", obi_rready, 1);

        // Read: accept, grant next cycle, response two cycles later
        send_cmd(1'b0, 32'h100, 8'hFF, '0);
        chk("read req cycle1", obi_req, 1);
        chk("read addr", obi_addr, 64'h100);
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0;
        chk("read req dropped", obi_req, 0);
        chk("read outstanding 1", outstanding, 1);
        tick();
        obi_rvalid = 1'b1; obi_rdata = 64'hDEADBEEF;
        chk("read no rsp yet", rsp_valid, 0);
        tick();
        obi_rvalid = 1'b0;
        chk("read rsp_valid", rsp_valid, 1);
        chk("read rsp_rdata", rsp_rdata, 64'hDEADBEEF);
        chk("read rsp_we", rsp_we, 0);
        chk("read outstanding 0", outstanding, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("read drained", rsp_valid, 0);

        // Grant stall on a write
        send_cmd(1'b1, 32'h2040, 8'h0F, 64'h1122334455667788);
        for (int i = 0; i < 5; i++) begin
            chk("stall req", obi_req, 1);
            chk("stall wdata", obi_wdata, 64'h1122334455667788);
            chk("stall cmd_ready", cmd_ready, 0);
            tick();
        end
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0;
        chk("stall cmd_ready back", cmd_ready, 1);
        obi_rvalid = 1'b1; obi_rdata = 64'h55;
        tick();
        obi_rvalid = 1'b0;
        chk("write rsp_we", rsp_we, 1);
        chk("write rsp_rdata zero", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: fill FIFO with 4 responses, then drain
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, 32'h3000 + 32'(i * 8), 8'hFF, '0);
            obi_gnt = 1'b1;
            tick();
            obi_gnt = 1'b0;
            obi_rvalid = 1'b1; obi_rdata = 64'h1000 + 64'(i);
            if (i == 3) chk("bp cmd_ready after 4th gnt", cmd_ready, 0);
            tick();
            obi_rvalid = 1'b0;
        end
        chk("bp cmd_ready full", cmd_ready, 0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp order", rsp_rdata, 64'h1000 + 64'(k));
            tick();
            if (k == 0) chk("bp cmd_ready returns", cmd_ready, 1);
        end
        rsp_ready = 1'b0;
        chk("bp empty", rsp_valid, 0);

        // Simultaneous grant (B) and rvalid (A, err)
        send_cmd(1'b0, 32'h4000, 8'hFF, '0);
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0;
        send_cmd(1'b0, 32'h4008, 8'hFF, '0);
        obi_gnt = 1'b1; obi_rvalid = 1'b1; obi_err = 1'b1; obi_rdata = 64'hAA;
        tick();
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_err = 1'b0;
        chk("sim outstanding", outstanding, 1);
        chk("sim A err", rsp_err, 1);
        chk("sim A data", rsp_rdata, 64'hAA);
        rsp_ready = 1'b1;
        obi_rvalid = 1'b1; obi_rdata = 64'hBB;
        tick();
        obi_rvalid = 1'b0;
        chk("sim B data", rsp_rdata, 64'hBB);
        chk("sim B err", rsp_err, 0);
        tick();
        rsp_ready = 1'b0;

        // Protocol error: rvalid with nothing outstanding
        chk("proto pre", proto_err, 0);
        obi_rvalid = 1'b1; obi_rdata = 64'h77;
        tick();
        obi_rvalid = 1'b0;
        chk("proto set", proto_err, 1);
        chk("proto fifo unchanged", rsp_valid, 0);

        // Timeout
        send_cmd(1'b0, 32'h5000, 8'hFF, '0);
        obi_gnt = 1'b1;
        tick();
        obi_gnt = 1'b0;
        repeat (TO - 1) tick();
        chk("timeout not yet", timeout_err, 0);
        tick();
        chk("timeout set", timeout_err, 1);
        obi_rvalid = 1'b1; obi_rdata = 64'h99; rsp_ready = 1'b1;
        tick();
        obi_rvalid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("timeout sticky", timeout_err, 1);

        // Reset with 2 outstanding and 1 buffered
        send_cmd(1'b0, 32'h6000, 8'hFF, '0);
        obi_gnt = 1'b1; tick(); obi_gnt = 1'b0;
        obi_rvalid = 1'b1; obi_rdata = 64'hC0; tick(); obi_rvalid = 1'b0;
        send_cmd(1'b0, 32'h6008, 8'hFF, '0);
        obi_gnt = 1'b1; tick(); obi_gnt = 1'b0;
        send_cmd(1'b1, 32'h6010, 8'h01, 64'h5);
        obi_gnt = 1'b1; tick(); obi_gnt = 1'b0;
        chk("pre-reset outstanding", outstanding, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst outstanding", outstanding, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst proto", proto_err, 0);
        chk("rst timeout", timeout_err, 0);
        chk("rst obi_req", obi_req, 0);
        chk("rst obi_addr", obi_addr, 0);
        chk("rst rready", obi_rready, 0);
        chk("rst cmd_ready", cmd_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post-reset rsp_valid", rsp_valid, 0);
        chk("post-reset cmd_ready", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
